div_unit: RTL and testbench

Multi-cycle unsigned divider in the execute stage, beside the single-cycle ALU. It takes over the divide and modulo operations (opcodes 4'b1100 and 4'b1101) so they no longer need a combinational 32-bit divider. Its result, zero flag and overflow flag feed the same EX result multiplexer as the ALU outputs. The pipeline stalls on `busy`.

---
 rtl/div_pkg.sv | 11 +
 rtl/div_step.sv | 17 +
 rtl/div_unit.sv | 79 +++++++
 tb/tb_div_unit.sv | 127 ++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared divider states, opcodes and counter sizing
package div_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [3:0] OP_DIV = 4'b1100;
    localparam logic [3:0] OP_REM = 4'b1101;
    localparam int DIV_WIDTH = 32;
    function automatic int cnt_width(input int w);
        return w > 1 ? $clog2(w) : 1;
    endfunction
    localparam int CNT_W = cnt_width(DIV_WIDTH);
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_next,
    output logic [WIDTH-1:0] quo_next
);
    logic [WIDTH+1:0] shifted;
    logic ge;
    assign shifted = {rem, quo[WIDTH-1]};
    assign ge = shifted >= {2'b0, divisor};
    assign rem_next = ge ? (WIDTH+1)'(shifted - {2'b0, divisor}) : shifted[WIDTH:0];
    assign quo_next = {quo[WIDTH-2:0], ge};
endmodule

// File: rtl/div_unit.sv
// div_unit: multi-cycle unsigned divide/remainder, one restoring step per cycle
module div_unit
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       operation,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] saida,
    output logic             zero,
    output logic             of
);
    localparam int CW = cnt_width(WIDTH);
    state_t state, next;
    logic [WIDTH:0] rem, rem_nx;
    logic [WIDTH-1:0] quo, quo_nx, dvs, zres, fin;
    logic [CW-1:0] cnt;
    logic op_rem, accept, last;
    assign accept = start && state != RUN && (operation == OP_DIV || operation == OP_REM);
    assign last = cnt == CW'(WIDTH-1);
    assign busy = state == RUN;
    assign done = state == DONE;
    assign zres = operation == OP_REM ? dataA : '1;
    assign fin = op_rem ? rem_nx[WIDTH-1:0] : quo_nx;
    div_step #(.WIDTH(WIDTH)) u_step (
        .rem(rem),
        .quo(quo),
        .divisor(dvs),
        .rem_next(rem_nx),
        .quo_next(quo_nx)
    );
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= next;
    always_comb begin
        next = state == RUN ? (last ? DONE : RUN)
             : accept ? (dataB == '0 ? DONE : RUN)
             : IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem <= '0;
            quo <= '0;
            dvs <= '0;
            cnt <= '0;
            op_rem <= 1'b0;
            saida <= '0;
            zero <= 1'b1;
            of <= 1'b0;
        end else if (accept) begin
            op_rem <= operation == OP_REM;
            if (dataB == '0) begin
                saida <= zres;
                zero <= zres == '0;
                of <= 1'b1;
            end else begin
                dvs <= dataB;
                quo <= dataA;
                rem <= '0;
                cnt <= '0;
            end
        end else if (busy) begin
            rem <= rem_nx;
            quo <= quo_nx;
            cnt <= cnt + 1'b1;
            if (last) begin
                saida <= fin;
                zero <= fin == '0;
                of <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed self-checking bench for div_unit
module tb_div_unit;
    localparam int W = 32;
    logic clk = 1'b0, rst_n = 1'b1, start = 1'b0;
    logic [3:0] operation = 4'b0;
    logic [W-1:0] dataA = '0, dataB = '0;
    logic busy, done, zero, of, busy_seen, seen;
    logic [W-1:0] saida;
    int checks = 0, errors = 0, cyc = 0, e0 = 0, d1 = 0, d2 = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    div_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .operation(operation),
        .dataA(dataA), .dataB(dataB), .busy(busy), .done(done),
        .saida(saida), .zero(zero), .of(of)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op);
        start = 1'b1; dataA = a; dataB = b; operation = op;
        @(posedge clk); #1;
        e0 = cyc;
        start = 1'b0; dataA = 32'hDEAD_BEEF; dataB = 32'd3;
    endtask

    task automatic wait_done(output int dc);
        int n = 0;
        busy_seen = busy;
        while (!done && n < 60) begin
            @(posedge clk); #1;
            busy_seen = busy_seen | busy;
            n++;
        end
        dc = cyc;
    endtask

    task automatic op_check(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [3:0] op, input logic [W-1:0] es, input logic ez,
                            input logic eo, input int elat);
        int dc;
        @(negedge clk);
        launch(a, b, op);
        wait_done(dc);
        check({tag, "_lat"}, W'(dc - e0 + 1), W'(elat));
        check({tag, "_saida"}, saida, es);
        check({tag, "_zero"}, W'(zero), W'(ez));
        check({tag, "_of"}, W'(of), W'(eo));
        check({tag, "_busy"}, W'(busy_seen), W'(elat > 1));
        @(posedge clk); #1;
        check({tag, "_pulse"}, W'(done), 0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #10;
        check("rst_busy", W'(busy), 0);
        check("rst_done", W'(done), 0);
        check("rst_saida", saida, 0);
        check("rst_zero", W'(zero), 1);
        check("rst_of", W'(of), 0);
        @(negedge clk) rst_n = 1'b1;

        op_check("div100_7", 100, 7, 4'b1100, 14, 0, 0, 33);
        op_check("rem100_7", 100, 7, 4'b1101, 2, 0, 0, 33);
        op_check("divmax_1", 32'hFFFF_FFFF, 1, 4'b1100, 32'hFFFF_FFFF, 0, 0, 33);
        op_check("div5_9", 5, 9, 4'b1100, 0, 1, 0, 33);
        op_check("rem5_9", 5, 9, 4'b1101, 5, 0, 0, 33);
        op_check("div1234_0", 1234, 0, 4'b1100, 32'hFFFF_FFFF, 0, 1, 1);
        op_check("rem1234_0", 1234, 0, 4'b1101, 1234, 0, 1, 1);

        @(negedge clk);
        start = 1'b1; operation = 4'b0000; dataA = 8; dataB = 2;
        @(posedge clk); #1 start = 1'b0;
        check("badop_busy", W'(busy), 0);
        check("badop_done", W'(done), 0);
        check("badop_held", saida, 1234);

        @(negedge clk);
        launch(100, 7, 4'b1100);
        repeat (9) @(posedge clk);
        #1 start = 1'b1; dataA = 50; dataB = 5; operation = 4'b1100;
        @(posedge clk); #1 start = 1'b0;
        wait_done(d1);
        check("ign_lat", W'(d1 - e0 + 1), 33);
        check("ign_saida", saida, 14);

        @(negedge clk);
        launch(100, 7, 4'b1100);
        repeat (14) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", W'(busy), 0);
        check("mid_rst_done", W'(done), 0);
        check("mid_rst_saida", saida, 0);
        check("mid_rst_zero", W'(zero), 1);
        check("mid_rst_of", W'(of), 0);
        @(negedge clk) rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            seen = seen | done | busy;
        end
        check("mid_rst_quiet", W'(seen), 0);
        op_check("div20_4", 20, 4, 4'b1100, 5, 0, 0, 33);

        @(negedge clk);
        launch(100, 7, 4'b1100);
        wait_done(d1);
        check("b2b_first", saida, 14);
        launch(81, 9, 4'b1100);
        wait_done(d2);
        check("b2b_second", saida, 9);
        check("b2b_gap", W'(d2 - d1), 33);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
